pipe_stage_reg: RTL

Parametrised pipeline-stage register with valid/ready handshake, optional skid buffer, synchronous flush and a stall counter. It is the successor to the fixed ID/EXE latch. Each instance carries one packed stage bundle (for example, the ID→EXE control and data fields) between two pipeline stages, so a downstream stall back-pressures upstream without combinational ready paths when SKID=1.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/pipe_stage_reg_sat_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: the handshake state encoding and the ID->EXE stage bundle.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       branchAddr;
    logic [REG_ADDR_W-1:0] writeAddr;
    logic [XLEN-1:0]       reg1;
    logic [XLEN-1:0]       reg2;
    logic [XLEN-1:0]       storeData;
    logic [XLEN-1:0]       writeData;
    logic [ALU_CTRL_W-1:0] aluCtrl;
    logic                  lwSel;
    logic                  movSel;
    logic                  regWrite;
    logic                  dmRead;
    logic                  dmWrite;
  } id_exe_bundle_t;

  localparam int ID_EXE_W = $bits(id_exe_bundle_t);

  // A NOP bundle: ALU idle, no register or memory side effects.
  localparam id_exe_bundle_t ID_EXE_NOP = '{
    pc: '0, branchAddr: '0, writeAddr: '0, reg1: '0, reg2: '0,
    storeData: '0, writeData: '0, aluCtrl: ALU_NOP, lwSel: 1'b0,
    movSel: 1'b0, regWrite: 1'b0, dmRead: 1'b0, dmWrite: 1'b0
  };

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; used to count downstream stall cycles.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Holds at all-ones instead of wrapping so long stalls stay visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 200,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              upFire, dnFire;

  assign dn_valid = (state_q != EMPTY);
  assign dn_data  = main_q;
  assign upFire   = up_valid & up_ready;
  assign dnFire   = dn_valid & dn_ready;

  generate
    if (SKID) begin : g_skid
      // Ready comes straight from the state register, breaking the ready path.
      assign up_ready = (state_q != FULL);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (upFire) begin
              main_d  = up_data;
              state_d = ONE;
            end
          end
          ONE: begin
            if (upFire && dnFire) begin
              main_d = up_data;
            end else if (dnFire) begin
              state_d = EMPTY;
            end else if (upFire) begin
              skid_d  = up_data;
              state_d = FULL;
            end
          end
          FULL: begin
            if (dnFire) begin
              main_d  = skid_q;
              state_d = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d = EMPTY;
          main_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      end
    end else begin : g_noskid
      assign up_ready = dn_ready | ~dn_valid;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = RESET_VAL;
        if (upFire) begin
          main_d  = up_data;
          state_d = ONE;
        end else if (dnFire) begin
          state_d = EMPTY;
        end
        if (flush) begin
          state_d = EMPTY;
          main_d  = RESET_VAL;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush leaves the stall history intact; only reset clears it.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dn_valid & ~dn_ready),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule
